// File: rtl/rv_pkg.sv
// Shared RV32I front-end definitions: widths, reset PC, canonical NOP and
// the fetch-buffer entry payload used between the IF stage and its buffers.
package rv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   RESET_PC = 32'h0100_0000;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // One buffered instruction together with the PC it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Force a byte address onto a 32-bit word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with flush, used for the fetch entry buffer
// and for the PC tags of outstanding requests.
// Ports:
//   clk, rst_n       clock, async active-low reset
//   push, din        write request and data (accepted when not full, or full with pop)
//   pop              read request (ignored when empty)
//   flush            discard all contents (wins over push/pop)
//   dout             head entry (combinational read)
//   full, empty      occupancy flags
//   count            number of stored entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; the counters define which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the five-stage RV32I pipeline: owns the PC, issues in-order
// instruction-memory requests, buffers returned words and presents one
// instruction per cycle to the IF/ID boundary. Handles decode stalls and EX
// redirects, discarding wrong-path words already in flight.
// Ports:
//   clock, reset_n                      clock, async active-low reset
//   imem_req_valid/ready/addr           fetch request handshake and word address
//   imem_rsp_valid/data                 in-order response word (latency >= 1)
//   redirect_valid, redirect_pc         taken branch/jump from EX (1-cycle pulse)
//   id_stall                            decode cannot accept the head this cycle
//   if_id_valid/inst/pc/pc4             head of the fetch buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = rv_pkg::NOP_INST
) (
  input  logic                     clock,
  input  logic                     reset_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [rv_pkg::XLEN-1:0]  imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [rv_pkg::INST_W-1:0] imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [rv_pkg::XLEN-1:0]  redirect_pc,
  input  logic                     id_stall,
  output logic                     if_id_valid,
  output logic [rv_pkg::INST_W-1:0] if_id_inst,
  output logic [rv_pkg::XLEN-1:0]  if_id_pc,
  output logic [rv_pkg::XLEN-1:0]  if_id_pc4
);

  import rv_pkg::*;

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;
  localparam int unsigned EW = $bits(fetch_entry_t);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   out_next;
  logic [CW:0]     occupancy;
  logic            req_hs;
  logic            rsp_keep;

  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic [CW-1:0]   buf_count;
  fetch_entry_t    buf_din;
  logic [EW-1:0]   buf_dout;
  fetch_entry_t    head;

  logic [XLEN-1:0] tag_pc;
  logic            tag_full;
  logic            tag_empty;
  logic [CW-1:0]   tag_count;

  // Issue cap: words requested but not returned plus words buffered never
  // exceed the buffer depth, so every kept response has a free slot.
  assign occupancy      = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req_valid = reset_n && !redirect_valid && (occupancy < (CW+1)'(BUF_DEPTH));
  assign imem_req_addr  = pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // Responses owed to a squashed path are swallowed until drop_cnt drains;
  // anything arriving in the redirect cycle itself is also wrong-path.
  assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt == '0);
  assign out_next = outstanding + CW'(req_hs) - CW'(imem_rsp_valid);

  assign buf_din = '{pc: tag_pc, inst: imem_rsp_data};
  assign buf_pop = if_id_valid && !id_stall;

  // PC and request bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect_valid) begin
        pc       <= word_align(redirect_pc);
        drop_cnt <= out_next;
      end else begin
        if (req_hs) pc <= pc + 32'd4;
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  // PC tags of live (not yet dropped) requests, in issue order.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_tag_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (req_hs),
    .pop   (rsp_keep),
    .flush (redirect_valid),
    .din   (pc),
    .dout  (tag_pc),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Instruction buffer feeding the IF/ID boundary.
  fetch_fifo #(.WIDTH(EW), .DEPTH(BUF_DEPTH)) u_entry_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .push  (rsp_keep),
    .pop   (buf_pop),
    .flush (redirect_valid),
    .din   (buf_din),
    .dout  (buf_dout),
    .full  (buf_full),
    .empty (buf_empty),
    .count (buf_count)
  );

  assign head        = fetch_entry_t'(buf_dout);
  assign if_id_valid = !buf_empty;
  assign if_id_inst  = if_id_valid ? head.inst : NOP_INST;
  assign if_id_pc    = if_id_valid ? head.pc : '0;
  assign if_id_pc4   = if_id_valid ? (head.pc + 32'd4) : '0;

  drop_le_outstanding: assert property (@(posedge clock) disable iff (!reset_n)
    drop_cnt <= outstanding);
  tags_match_live: assert property (@(posedge clock) disable iff (!reset_n)
    tag_count == (outstanding - drop_cnt));
  tag_no_underflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(rsp_keep && tag_empty));
  tag_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(req_hs && tag_full));
  buf_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(rsp_keep && buf_full && !buf_pop));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a start-up vector table plus hand-written
// stall, redirect, random-ready and mid-stream reset sequences. A small
// in-order memory model answers one cycle after acceptance (or is held off),
// and a stream monitor tracks the next expected head PC.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0100_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clock;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  fetch_stage dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_inst     (if_id_inst),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int          checks;
  int          errors;
  int          issued;
  int          popped;
  logic [31:0] exp_pc;
  bit          mon_en;
  bit          mem_hold;
  logic [31:0] addr_q [$];

  typedef struct {
    logic        ready;
    logic        stall;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_v;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t tbl [7];

  // Memory contents: distinct per address and never equal to the NOP.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // One clock cycle: check the head against the expected stream, record
  // handshakes, cross the edge, then present the memory's next response.
  task automatic tick();
    bit          hs;
    bit          pop;
    bit          redir;
    logic [31:0] tgt;
    #1;
    hs    = reset_n && imem_req_valid && imem_req_ready;
    pop   = reset_n && if_id_valid && !id_stall;
    redir = reset_n && redirect_valid;
    tgt   = redirect_pc;
    if (mon_en) begin
      if (if_id_valid) begin
        chk("head_pc", if_id_pc, exp_pc);
        chk("head_inst", if_id_inst, inst_of(exp_pc));
        chk("head_pc4", if_id_pc4, exp_pc + 32'd4);
      end else begin
        chk("nop_when_invalid", if_id_inst, NOP);
      end
    end
    if (hs) begin
      addr_q.push_back(imem_req_addr);
      issued++;
    end
    if (pop) popped++;
    @(posedge clock);
    #1;
    if (redir)    exp_pc = {tgt[31:2], 2'b00};
    else if (pop) exp_pc = exp_pc + 32'd4;
    if (!mem_hold && addr_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = inst_of(addr_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic wait_req(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (imem_req_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (if_id_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  // Let requests go out unanswered until two are in flight and the buffer is empty.
  task automatic fill_in_flight(input string name);
    bit ok;
    ok = 0;
    mem_hold = 1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (addr_q.size() == 2 && !if_id_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    checks = 0; errors = 0; issued = 0; popped = 0;
    exp_pc = RST_PC; mon_en = 0; mem_hold = 0;

    // Start-up stream, ready=1, 1-cycle memory, no stall (cycle 0 = first after release).
    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h0100_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h0100_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h0100_0008, 1'b1, 32'h0100_0004};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 32'h0100_000C, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0100_0008};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 32'h0100_0010, 1'b1, 32'h0100_000C};

    reset_n = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    chk("rst_inst", if_id_inst, NOP);
    chk("rst_pc", if_id_pc, 32'd0);
    chk("rst_pc4", if_id_pc4, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    exp_pc = RST_PC; issued = 0; popped = 0; mon_en = 1;

    for (int i = 0; i < 7; i++) begin
      imem_req_ready = tbl[i].ready;
      id_stall       = tbl[i].stall;
      #1;
      chk($sformatf("t%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("t%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
      chk($sformatf("t%0d_valid", i), 32'(if_id_valid), 32'(tbl[i].exp_v));
      chk($sformatf("t%0d_pc", i), if_id_pc, tbl[i].exp_v ? tbl[i].exp_pc : 32'h0);
      chk($sformatf("t%0d_pc4", i), if_id_pc4, tbl[i].exp_v ? tbl[i].exp_pc + 32'd4 : 32'h0);
      chk($sformatf("t%0d_inst", i), if_id_inst, tbl[i].exp_v ? inst_of(tbl[i].exp_pc) : NOP);
      tick();
    end

    // Stall for 5 cycles: head frozen, fetch capped at BUF_DEPTH words.
    id_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_cap", 32'((issued - popped) <= 2), 32'd1);
    end
    #1;
    chk("stall_head_valid", 32'(if_id_valid), 32'd1);
    id_stall = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Redirect to a misaligned target with two responses in flight.
    fill_in_flight("fill_1");
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0102;
    #1;
    chk("redir1_req_blocked", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0; mem_hold = 0;
    wait_req("redir1_req", 10);
    chk("redir1_req_addr", imem_req_addr, 32'h0100_0100);
    wait_valid("redir1_valid", 10);
    chk("redir1_first_pc", if_id_pc, 32'h0100_0100);
    for (int i = 0; i < 6; i++) tick();

    // Response and redirect in the same cycle; one old word still in flight.
    fill_in_flight("fill_2");
    mem_hold = 0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h0100_0200;
    #1;
    chk("redir2_req_blocked", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    wait_req("redir2_req", 10);
    chk("redir2_req_addr", imem_req_addr, 32'h0100_0200);
    wait_valid("redir2_valid", 10);
    chk("redir2_first_pc", if_id_pc, 32'h0100_0200);

    // Memory ready toggling randomly.
    p0 = popped;
    for (int i = 0; i < 200; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      tick();
    end
    imem_req_ready = 1'b1;
    chk("random_progress", 32'((popped - p0) >= 10), 32'd1);

    // Fill the buffer under stall, then reset mid-stream.
    id_stall = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    #1;
    chk("pre_reset_full_valid", 32'(if_id_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(if_id_valid), 32'd0);
    chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("midrst_inst", if_id_inst, NOP);
    chk("midrst_pc", if_id_pc, 32'd0);
    addr_q.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tick();
    tick();
    reset_n = 1'b1; id_stall = 1'b0; exp_pc = RST_PC;
    wait_req("restart_req", 5);
    chk("restart_req_addr", imem_req_addr, RST_PC);
    wait_valid("restart_valid", 10);
    chk("restart_first_pc", if_id_pc, RST_PC);
    for (int i = 0; i < 10; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
